// File: rtl/divider_if.sv
// divider_if: operand buttons/switches in, result registers and status out
interface divider_if;
  logic       Load_Dividend;
  logic       Load_Divisor;
  logic       Run;
  logic [7:0] SW;
  logic [7:0] Qval;
  logic [7:0] Rval;
  logic [7:0] Nval;
  logic [7:0] Dval;
  logic       Busy;
  logic       Done;
  logic       DivZero;
  logic       Ovf;
  modport master (output Load_Dividend, Load_Divisor, Run, SW,
                  input  Qval, Rval, Nval, Dval, Busy, Done, DivZero, Ovf);
  modport slave  (input  Load_Dividend, Load_Divisor, Run, SW,
                  output Qval, Rval, Nval, Dval, Busy, Done, DivZero, Ovf);
endinterface

// File: rtl/divider.sv
// divider: 8-bit sequential restoring divider, one quotient bit per clock; DIV_SIGNED_EN selects two's complement operands
module divider (
  input  logic      Clk,
  input  logic      Reset_n,
  divider_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] ldn_s, ldd_s, run_s;
  logic [7:0] sw_m, sw_s, nval, dval, q, n_mag, d_mag, q_step, q_fix, r_fix;
  logic [8:0] r, t, r_step;
  logic [2:0] cnt;
  logic       div_zero, ovf, ev_ln, ev_ld, ev_run, load_ev, idle_done, last, n_neg, d_neg, ovf_hit;
  // bits [1:0] are the synchronizer, bit [2] the previous value for edge detection
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      ldn_s <= '0;
      ldd_s <= '0;
      run_s <= '0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      ldn_s <= {ldn_s[1:0], bus.Load_Dividend};
      ldd_s <= {ldd_s[1:0], bus.Load_Divisor};
      run_s <= {run_s[1:0], bus.Run};
      sw_m  <= bus.SW;
      sw_s  <= sw_m;
    end
  // state register
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  // events, one divide step with sign fix-up, and next state; loads take priority over Run
  always_comb begin
    ev_ln     = ldn_s[1] & ~ldn_s[2];
    ev_ld     = ldd_s[1] & ~ldd_s[2];
    ev_run    = run_s[1] & ~run_s[2];
    load_ev   = ev_ln | ev_ld;
    idle_done = state != COMPUTE;
    last      = cnt == 3'd7;
`ifdef DIV_SIGNED_EN
    n_neg     = nval[7];
    d_neg     = dval[7];
    ovf_hit   = nval == 8'h80 && dval == 8'hFF;
`else
    n_neg     = 1'b0;
    d_neg     = 1'b0;
    ovf_hit   = 1'b0;
`endif
    n_mag     = n_neg ? -nval : nval;
    d_mag     = d_neg ? -dval : dval;
    t         = {r[7:0], q[7]} - {1'b0, d_mag};
    r_step    = t[8] ? {r[7:0], q[7]} : t;
    q_step    = {q[6:0], ~t[8]};
    q_fix     = (n_neg ^ d_neg) ? -q_step : q_step;
    r_fix     = n_neg ? -r_step[7:0] : r_step[7:0];
    state_nx  = idle_done ? (load_ev ? IDLE : ev_run ? (dval == 8'd0 ? DONE : COMPUTE) : state)
                          : (last ? DONE : COMPUTE);
  end
  // operand loads, divide start, and per-cycle quotient/remainder update
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      nval     <= '0;
      dval     <= '0;
      q        <= '0;
      r        <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else if (idle_done && load_ev) begin
      if (ev_ln) nval <= sw_s;
      if (ev_ld) dval <= sw_s;
    end else if (idle_done && ev_run) begin
      if (dval == 8'd0) begin
        div_zero <= 1'b1;
        q        <= 8'hFF;
        r        <= {1'b0, nval};
      end else begin
        div_zero <= 1'b0;
        ovf      <= 1'b0;
        r        <= '0;
        q        <= n_mag;
        cnt      <= '0;
      end
    end else if (!idle_done) begin
      r   <= last ? {1'b0, r_fix} : r_step;
      q   <= last ? q_fix : q_step;
      cnt <= cnt + 3'd1;
      if (last) ovf <= ovf_hit;
    end
  assign bus.Qval    = q;
  assign bus.Rval    = r[7:0];
  assign bus.Nval    = nval;
  assign bus.Dval    = dval;
  assign bus.Busy    = state == COMPUTE;
  assign bus.Done    = state == DONE;
  assign bus.DivZero = div_zero;
  assign bus.Ovf     = ovf;
endmodule
